// File: rtl/alu_operand_pkg.sv
// Shared encodings for the ALU operand-B conditioning stage.
package alu_operand_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STATE_W = 2;

  // Immediate-conditioning modes applied to the selected source.
  typedef enum logic [MODE_W-1:0] {
    MODE_PASS     = 2'b00,
    MODE_SEXT     = 2'b01,
    MODE_ZEXT     = 2'b10,
    MODE_SEXT_SL2 = 2'b11
  } mode_e;

  // Skid-buffer occupancy: nothing, main register only, main plus skid.
  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_operand_stage_operand_condition.sv
// Combinational source select plus immediate extend/shift for operand B.
module operand_condition
  import alu_operand_pkg::*;
#(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned NUM_SRC = 6,
  parameter  int unsigned IMM_W   = 16,
  localparam int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [MODE_W-1:0]         i_mode,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
  output logic [DATA_W-1:0]         o_data_c,
  output logic                      o_err_c
);

  if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
    $error("operand_condition: NUM_SRC must be in 2..16");
  end
  if (IMM_W + 2 >= DATA_W) begin : g_bad_imm_w
    $error("operand_condition: IMM_W must be below DATA_W - 2");
  end

  logic [DATA_W-1:0] w_raw;
  logic              w_err;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_sext_sl2;

  // Source mux; an index past the last source yields zero and flags an error.
  always_comb begin
    w_raw = '0;
    w_err = 1'b1;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_raw = i_src_data[k*DATA_W +: DATA_W];
        w_err = 1'b0;
      end
    end
  end

  assign w_sext     = {{(DATA_W-IMM_W){w_raw[IMM_W-1]}}, w_raw[IMM_W-1:0]};
  assign w_zext     = {{(DATA_W-IMM_W){1'b0}}, w_raw[IMM_W-1:0]};
  assign w_sext_sl2 = {w_sext[DATA_W-3:0], 2'b00};

  // Apply the conditioning mode to the selected source.
  always_comb begin
    o_data_c = w_raw;
    o_err_c  = w_err;
    case (mode_e'(i_mode))
      MODE_PASS:     o_data_c = w_raw;
      MODE_SEXT:     o_data_c = w_sext;
      MODE_ZEXT:     o_data_c = w_zext;
      MODE_SEXT_SL2: o_data_c = w_sext_sl2;
      default:       o_data_c = w_raw;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-B select/condition stage behind a 2-entry valid/ready skid buffer.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned NUM_SRC = 6,
  parameter  int unsigned IMM_W   = 16,
  localparam int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic [MODE_W-1:0]         mode,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_err
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_err;
  logic [DATA_W-1:0] r_s_data;
  logic              r_s_err;

  logic [DATA_W-1:0] w_cond_data;
  logic              w_cond_err;
  logic              w_accept;
  logic              w_consume;
  logic              w_m_load_new;
  logic              w_m_load_skid;
  logic              w_s_load;

  operand_condition #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .IMM_W   (IMM_W)
  ) u_operand_condition (
    .i_sel      (sel),
    .i_mode     (mode),
    .i_src_data (src_data),
    .o_data_c   (w_cond_data),
    .o_err_c    (w_cond_err)
  );

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = r_out_valid & out_ready;

  // Next-state and register-load decode for the skid buffer.
  always_comb begin
    w_state_nxt   = r_state;
    w_m_load_new  = 1'b0;
    w_m_load_skid = 1'b0;
    w_s_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt  = ST_ONE;
          w_m_load_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && !w_consume) begin
          w_state_nxt = ST_FULL;
          w_s_load    = 1'b1;
        end else if (w_accept && w_consume) begin
          w_m_load_new = 1'b1;
        end else if (w_consume) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_consume) begin
          w_state_nxt   = ST_ONE;
          w_m_load_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register; handshake outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Main and skid operand registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_data <= '0;
      r_m_err  <= 1'b0;
      r_s_data <= '0;
      r_s_err  <= 1'b0;
    end else begin
      if (w_m_load_new) begin
        r_m_data <= w_cond_data;
        r_m_err  <= w_cond_err;
      end else if (w_m_load_skid) begin
        r_m_data <= r_s_data;
        r_m_err  <= r_s_err;
      end
      if (w_s_load) begin
        r_s_data <= w_cond_data;
        r_s_err  <= w_cond_err;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_m_data;
  assign out_err   = r_m_err;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: select, modes, backpressure, reset.
module tb_alu_operand_stage;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_SRC = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned SEL_W   = 3;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          sel;
  logic [1:0]                mode;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_err;

  int n_checks = 0;
  int n_errors = 0;

  alu_operand_stage #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .IMM_W   (IMM_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .src_data  (src_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic load_sweep_sources();
    for (int k = 0; k < int'(NUM_SRC); k++)
      src_data[k*DATA_W +: DATA_W] = 32'h1000_0000 + 32'(k);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = '0;
    mode      = 2'b00;
    src_data  = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_err, out_data} !== 34'd0) begin
      n_errors++;
      $display("FAIL reset_hold: got v=%0b e=%0b d=%h, want v=0 e=0 d=0", out_valid, out_err, out_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL reset_release: got in_ready=%0b out_valid=%0b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_pass_sweep();
    load_sweep_sources();
    out_ready = 1'b1;
    mode      = 2'b00;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      sel      = SEL_W'(i);
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_err, out_data} !== {1'b1, 1'b1, 1'b0, 32'h1000_0000 + 32'(i)}) begin
        n_errors++;
        $display("FAIL pass_sweep[%0d]: got rdy=%0b v=%0b e=%0b d=%h, want 1 1 0 %h",
                 i, in_ready, out_valid, out_err, out_data, 32'h1000_0000 + 32'(i));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL pass_sweep_drain: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_modes();
    logic [31:0] t_src  [7] = '{32'h0000_8004, 32'h0000_8004, 32'h0000_8004, 32'h0000_7FFF,
                                32'hABCD_8004, 32'hABCD_7FFF, 32'hABCD_8004};
    logic [1:0]  t_mode [7] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10};
    logic [31:0] t_exp  [7] = '{32'hFFFF_8004, 32'h0000_8004, 32'hFFFE_0010, 32'h0001_FFFC,
                                32'hABCD_8004, 32'h0000_7FFF, 32'h0000_8004};
    out_ready = 1'b1;
    sel       = '0;
    for (int i = 0; i < 7; i++) begin
      src_data[0 +: DATA_W] = t_src[i];
      mode     = t_mode[i];
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, t_exp[i]}) begin
        n_errors++;
        $display("FAIL mode[%0d] src=%h mode=%0d: got v=%0b e=%0b d=%h, want 1 0 %h",
                 i, t_src[i], t_mode[i], out_valid, out_err, out_data, t_exp[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    logic [SEL_W-1:0] t_sel [3] = '{3'd7, 3'd6, 3'd2};
    logic             t_err [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0]      t_exp [3] = '{32'h0, 32'h0, 32'h1000_0002};
    load_sweep_sources();
    out_ready = 1'b1;
    mode      = 2'b00;
    for (int i = 0; i < 3; i++) begin
      sel      = t_sel[i];
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_err, out_data} !== {1'b1, t_err[i], t_exp[i]}) begin
        n_errors++;
        $display("FAIL sel_range sel=%0d: got v=%0b e=%0b d=%h, want 1 %0b %h",
                 t_sel[i], out_valid, out_err, out_data, t_err[i], t_exp[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    mode      = 2'b00;
    sel       = '0;
    src_data[0 +: DATA_W] = 32'hA0A0_0001;
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 32'hA0A0_0001}) begin
      n_errors++;
      $display("FAIL bp_a_held: got rdy=%0b v=%0b d=%h, want 1 1 a0a00001", in_ready, out_valid, out_data);
    end
    src_data[0 +: DATA_W] = 32'hB0B0_0002;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'hA0A0_0001}) begin
      n_errors++;
      $display("FAIL bp_full: got rdy=%0b v=%0b d=%h, want 0 1 a0a00001", in_ready, out_valid, out_data);
    end
    src_data[0 +: DATA_W] = 32'hC0C0_0003;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'hA0A0_0001}) begin
      n_errors++;
      $display("FAIL bp_c_blocked: got rdy=%0b v=%0b d=%h, want 0 1 a0a00001", in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 32'hB0B0_0002}) begin
      n_errors++;
      $display("FAIL bp_deliver_b: got rdy=%0b v=%0b d=%h, want 1 1 b0b00002", in_ready, out_valid, out_data);
    end
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 32'hC0C0_0003}) begin
      n_errors++;
      $display("FAIL bp_deliver_c: got rdy=%0b v=%0b d=%h, want 1 1 c0c00003", in_ready, out_valid, out_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_no_dup: got out_valid=%0b d=%h, want out_valid 0", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    out_ready = 1'b1;
    mode      = 2'b00;
    sel       = '0;
    for (int i = 0; i < 20; i++) begin
      w = $urandom;
      src_data[0 +: DATA_W] = w;
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_err, out_data} !== {1'b1, 1'b1, 1'b0, w}) begin
        n_errors++;
        $display("FAIL b2b[%0d]: got rdy=%0b v=%0b e=%0b d=%h, want 1 1 0 %h",
                 i, in_ready, out_valid, out_err, out_data, w);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    mode      = 2'b00;
    sel       = '0;
    src_data[0 +: DATA_W] = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    @(negedge clk);
    src_data[0 +: DATA_W] = 32'h1234_5678;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin
      n_errors++;
      $display("FAIL rst_mid_full: got rdy=%0b v=%0b d=%h, want 0 1 deadbeef", in_ready, out_valid, out_data);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_err, out_data} !== 34'd0) begin
      n_errors++;
      $display("FAIL rst_mid_async: got v=%0b e=%0b d=%h, want 0 0 0", out_valid, out_err, out_data);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_err, out_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL rst_mid_release: got rdy=%0b v=%0b e=%0b d=%h, want 1 0 0 0",
               in_ready, out_valid, out_err, out_data);
    end
    src_data[0 +: DATA_W] = 32'h0F0F_0F0F;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h0F0F_0F0F}) begin
      n_errors++;
      $display("FAIL rst_mid_resume: got v=%0b d=%h, want 1 0f0f0f0f", out_valid, out_data);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_no_stale: got out_valid=%0b d=%h, want 0", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_pass_sweep();
    test_modes();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
